// File: rtl/mult64_pkg.sv
// -----------------------------------------------------------------------------
// mult64_pkg
//   Constants shared by the streaming wrapper around mult64x64_top.
//   OPWIDTH        operand width of the multiplier
//   PWIDTH         product width (2*OPWIDTH)
//   MULT_LAT_RTL   multiplier latency of the RTL model, in cycles
//   MULT_LAT_GATE  multiplier latency of the gate-level netlist, in cycles
//   FIFO_DEP_DEF   default result FIFO depth (power of two, >= 2)
// -----------------------------------------------------------------------------
package mult64_pkg;

  localparam int OPWIDTH       = 64;
  localparam int PWIDTH        = 2 * OPWIDTH;
  localparam int MULT_LAT_RTL  = 5;
  localparam int MULT_LAT_GATE = 8;
  localparam int FIFO_DEP_DEF  = 8;

endpackage

// File: rtl/mult64_stream_ctrl_if.sv
// -----------------------------------------------------------------------------
// mult64_stream_ctrl_if
//   Bundles everything mult64_stream_ctrl talks to besides clock and reset:
//   the upstream operand stream, the multiplier operand/product wires and the
//   downstream result stream.
//   slave  : the controller's view (takes operands and products, drives results)
//   master : the environment's view (source, multiplier, sink)
//   Operand side : i_in_valid, o_in_ready, i_in_a, i_in_b, i_in_signed
//   Multiplier   : o_mult_a, o_mult_b, o_mult_ns, i_mult_product
//   Result side  : o_out_valid, i_out_ready, o_out_product, o_inflight
// -----------------------------------------------------------------------------
interface mult64_stream_ctrl_if #(
  parameter int OPWIDTH  = mult64_pkg::OPWIDTH,
  parameter int FIFO_DEP = mult64_pkg::FIFO_DEP_DEF
);

  localparam int CW = $clog2(FIFO_DEP + 1);

  logic                   i_in_valid;
  logic                   o_in_ready;
  logic [OPWIDTH-1:0]     i_in_a;
  logic [OPWIDTH-1:0]     i_in_b;
  logic                   i_in_signed;

  logic [OPWIDTH-1:0]     o_mult_a;
  logic [OPWIDTH-1:0]     o_mult_b;
  logic                   o_mult_ns;
  logic [2*OPWIDTH-1:0]   i_mult_product;

  logic                   o_out_valid;
  logic                   i_out_ready;
  logic [2*OPWIDTH-1:0]   o_out_product;
  logic [CW-1:0]          o_inflight;

  modport slave (
    input  i_in_valid, i_in_a, i_in_b, i_in_signed, i_mult_product, i_out_ready,
    output o_in_ready, o_mult_a, o_mult_b, o_mult_ns, o_out_valid, o_out_product,
           o_inflight
  );

  modport master (
    output i_in_valid, i_in_a, i_in_b, i_in_signed, i_mult_product, i_out_ready,
    input  o_in_ready, o_mult_a, o_mult_b, o_mult_ns, o_out_valid, o_out_product,
           o_inflight
  );

endinterface

// File: rtl/mult64_res_fifo.sv
// -----------------------------------------------------------------------------
// mult64_res_fifo
//   Synchronous first-word-fall-through FIFO holding multiplier results.
//   clk, rst : clock, synchronous active-high reset (clears pointers only)
//   push,din : write din when push and not full
//   pop      : drop the head entry when pop and not empty
//   dout     : head entry, valid whenever !empty
//   full     : DEPTH entries stored
//   empty    : no entries stored
//   A push into an empty FIFO becomes visible on the following cycle; there
//   is no write-to-read bypass.
// -----------------------------------------------------------------------------
module mult64_res_fifo
  import mult64_pkg::*;
#(
  parameter int WIDTH = PWIDTH,
  parameter int DEPTH = FIFO_DEP_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int            AW      = $clog2(DEPTH);
  localparam logic [AW:0]   PTR_ONE = (AW+1)'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // The extra MSB tells a full FIFO (same index, different lap) from an empty one.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // NOTE: the storage array has no reset; the pointers alone decide what is
  // valid, and leaving the array unreset lets it map onto plain RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

  assign dout = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/mult64_stream_ctrl.sv
// -----------------------------------------------------------------------------
// mult64_stream_ctrl
//   Valid/ready front and back end for the fixed-latency mult64x64_top, which
//   sits beside this block and is wired through the bus interface.
//   i_clk       : clock, all logic on the rising edge
//   i_rst       : synchronous active-high reset; drops in-flight products
//   bus (slave) : operand stream in, multiplier operands out, multiplier
//                 product in, result stream out, in-flight count out
//   Operands are registered onto the multiplier on each accepted pair. A tag
//   shift register follows each pair through the multiplier so that only real
//   products are written into the result FIFO. Issue is credit-limited by the
//   number of results not yet popped, so the FIFO always has room.
// -----------------------------------------------------------------------------
module mult64_stream_ctrl #(
  parameter int OPWIDTH  = mult64_pkg::OPWIDTH,
  parameter int MULT_LAT = mult64_pkg::MULT_LAT_RTL,
  parameter int FIFO_DEP = mult64_pkg::FIFO_DEP_DEF
) (
  input  logic                i_clk,
  input  logic                i_rst,
  mult64_stream_ctrl_if.slave bus
);

  localparam int            PW         = 2 * OPWIDTH;
  localparam int            CW         = $clog2(FIFO_DEP + 1);
  localparam logic [CW-1:0] CREDIT_MAX = CW'(FIFO_DEP);
  localparam logic [CW-1:0] CW_ONE     = CW'(1);

  logic [OPWIDTH-1:0] mult_a;
  logic [OPWIDTH-1:0] mult_b;
  logic               mult_ns;
  logic [MULT_LAT:0]  tag;
  logic [CW-1:0]      inflight;
  logic               in_ready;
  logic               fire;
  logic               push;
  logic               pop;
  logic               fifo_full;
  logic               fifo_empty;
  logic [PW-1:0]      fifo_head;

  // Ready is held low while reset is asserted, so it rises in the very first
  // cycle after reset without waiting for another edge.
  assign in_ready = !i_rst && (inflight < CREDIT_MAX);
  assign fire     = bus.i_in_valid && in_ready;
  assign pop      = !fifo_empty && bus.i_out_ready;

  // tag[k] is set k edges after the issue edge. The multiplier output for a
  // pair loaded at edge t is present in the cycle after edge t+MULT_LAT, which
  // is exactly when tag[MULT_LAT] is high, so that bit is the FIFO write strobe.
  assign push = tag[MULT_LAT];

  // NOTE: state registers use non-blocking assignment so every register in
  // this block samples the pre-edge values of the others.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      mult_a   <= '0;
      mult_b   <= '0;
      mult_ns  <= 1'b0;
      tag      <= '0;
      inflight <= '0;
    end else begin
      // Operands hold between issues; those bubbles carry a zero tag.
      if (fire) begin
        mult_a  <= bus.i_in_a;
        mult_b  <= bus.i_in_b;
        mult_ns <= bus.i_in_signed;
      end
      tag <= {tag[MULT_LAT-1:0], fire};
      case ({fire, pop})
        2'b10:   inflight <= inflight + CW_ONE;
        2'b01:   inflight <= inflight - CW_ONE;
        default: ;
      endcase
    end
  end

  mult64_res_fifo #(
    .WIDTH (PW),
    .DEPTH (FIFO_DEP)
  ) u_res_fifo (
    .clk   (i_clk),
    .rst   (i_rst),
    .push  (push),
    .din   (bus.i_mult_product),
    .pop   (pop),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign bus.o_in_ready    = in_ready;
  assign bus.o_mult_a      = mult_a;
  assign bus.o_mult_b      = mult_b;
  assign bus.o_mult_ns     = mult_ns;
  assign bus.o_out_valid   = !fifo_empty;
  // Unwritten storage is never exposed: the product reads zero when empty.
  assign bus.o_out_product = fifo_empty ? '0 : fifo_head;
  assign bus.o_inflight    = inflight;

  // Credits bound the products in flight to the FIFO depth, so a push can
  // never meet a full FIFO unless the credit logic is broken.
  push_never_full : assert property (@(posedge i_clk) disable iff (i_rst) !(push && fifo_full))
    else $error("mult64_stream_ctrl: result pushed into a full FIFO");

endmodule

// File: tb/tb_mult64_stream_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mult64_stream_ctrl
//   Two controllers share one stimulus: dut5 runs against a 5-cycle
//   behavioural multiplier, dut8 against an 8-cycle one. use8 picks which
//   controller's outputs the bench observes. Expected products are queued in
//   issue order when a pair is accepted and compared when a result is popped.
// -----------------------------------------------------------------------------
module tb_mult64_stream_ctrl;
  import mult64_pkg::*;

  localparam int CW = $clog2(FIFO_DEP_DEF + 1);

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               in_valid = 1'b0;
  logic [63:0]        in_a = '0;
  logic [63:0]        in_b = '0;
  logic               in_signed = 1'b0;
  logic               out_ready = 1'b0;
  logic               use8 = 1'b0;

  logic [127:0]       sb [$];
  int                 checks = 0;
  int                 failures = 0;

  always #5 clk = ~clk;

  mult64_stream_ctrl_if #(.OPWIDTH(OPWIDTH), .FIFO_DEP(FIFO_DEP_DEF)) bus5 ();
  mult64_stream_ctrl_if #(.OPWIDTH(OPWIDTH), .FIFO_DEP(FIFO_DEP_DEF)) bus8 ();

  assign bus5.i_in_valid  = in_valid;
  assign bus5.i_in_a      = in_a;
  assign bus5.i_in_b      = in_b;
  assign bus5.i_in_signed = in_signed;
  assign bus5.i_out_ready = out_ready;
  assign bus8.i_in_valid  = in_valid;
  assign bus8.i_in_a      = in_a;
  assign bus8.i_in_b      = in_b;
  assign bus8.i_in_signed = in_signed;
  assign bus8.i_out_ready = out_ready;

  mult64_stream_ctrl #(.OPWIDTH(OPWIDTH), .MULT_LAT(MULT_LAT_RTL), .FIFO_DEP(FIFO_DEP_DEF))
    dut5 (.i_clk(clk), .i_rst(rst), .bus(bus5.slave));
  mult64_stream_ctrl #(.OPWIDTH(OPWIDTH), .MULT_LAT(MULT_LAT_GATE), .FIFO_DEP(FIFO_DEP_DEF))
    dut8 (.i_clk(clk), .i_rst(rst), .bus(bus8.slave));

  function automatic logic [127:0] mul(input logic [63:0] a, input logic [63:0] b,
                                       input logic s);
    logic [127:0] xa;
    logic [127:0] xb;
    xa = s ? {{64{a[63]}}, a} : {64'd0, a};
    xb = s ? {{64{b[63]}}, b} : {64'd0, b};
    return xa * xb;
  endfunction

  // Behavioural multipliers: product appears MULT_LAT cycles after the operands.
  logic [127:0] m5 [MULT_LAT_RTL];
  logic [127:0] m8 [MULT_LAT_GATE];
  always @(posedge clk) begin
    m5[0] <= mul(bus5.o_mult_a, bus5.o_mult_b, bus5.o_mult_ns);
    for (int i = 1; i < MULT_LAT_RTL; i++) m5[i] <= m5[i-1];
    m8[0] <= mul(bus8.o_mult_a, bus8.o_mult_b, bus8.o_mult_ns);
    for (int i = 1; i < MULT_LAT_GATE; i++) m8[i] <= m8[i-1];
  end
  assign bus5.i_mult_product = m5[MULT_LAT_RTL-1];
  assign bus8.i_mult_product = m8[MULT_LAT_GATE-1];

  logic          sel_in_ready;
  logic          sel_out_valid;
  logic [127:0]  sel_out_product;
  logic [CW-1:0] sel_inflight;
  assign sel_in_ready    = use8 ? bus8.o_in_ready    : bus5.o_in_ready;
  assign sel_out_valid   = use8 ? bus8.o_out_valid   : bus5.o_out_valid;
  assign sel_out_product = use8 ? bus8.o_out_product : bus5.o_out_product;
  assign sel_inflight    = use8 ? bus8.o_inflight    : bus5.o_inflight;

  // Drives one cycle's inputs at the falling edge and reports what the next
  // rising edge will do: accept a pair (queued as expected) and/or pop the head.
  task automatic cycle(input logic v, input logic [63:0] a, input logic [63:0] b,
                       input logic s, input logic r, output logic issued,
                       output logic popped, output logic [127:0] got,
                       output logic [CW-1:0] infl);
    @(negedge clk);
    in_valid  = v;
    in_a      = a;
    in_b      = b;
    in_signed = s;
    out_ready = r;
    #1;
    issued = v && sel_in_ready;
    popped = sel_out_valid && r;
    got    = sel_out_product;
    infl   = sel_inflight;
    if (issued) sb.push_back(mul(a, b, s));
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus5.o_in_ready !== 1'b0) begin
      failures++; $display("FAIL reset_in_ready got=%b exp=0", bus5.o_in_ready);
    end
    checks++;
    if (bus5.o_out_valid !== 1'b0) begin
      failures++; $display("FAIL reset_out_valid got=%b exp=0", bus5.o_out_valid);
    end
    checks++;
    if (bus5.o_inflight !== '0) begin
      failures++; $display("FAIL reset_inflight got=%0d exp=0", bus5.o_inflight);
    end
    checks++;
    if (bus5.o_mult_a !== '0 || bus5.o_mult_ns !== 1'b0 || bus5.o_out_product !== '0) begin
      failures++;
      $display("FAIL reset_outputs mult_a=%h ns=%b product=%h exp=0",
               bus5.o_mult_a, bus5.o_mult_ns, bus5.o_out_product);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (bus5.o_in_ready !== 1'b1) begin
      failures++; $display("FAIL ready_after_reset got=%b exp=1", bus5.o_in_ready);
    end
  endtask

  task automatic test_single_unsigned();
    logic iss, pop;
    logic [127:0] got, prod;
    logic [CW-1:0] infl;
    int lat;
    lat = -1;
    prod = '0;
    cycle(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 1'b0, 1'b1, iss, pop, got, infl);
    checks++;
    if (iss !== 1'b1) begin
      failures++; $display("FAIL single_accept got=%b exp=1", iss);
    end
    // Observation k is taken after the k-th edge following the issue edge.
    for (int k = 0; k < 20 && lat < 0; k++) begin
      cycle(1'b0, '0, '0, 1'b0, 1'b1, iss, pop, got, infl);
      if (pop) begin
        lat = k;
        prod = got;
      end
    end
    checks++;
    if (lat != MULT_LAT_RTL + 1) begin
      failures++; $display("FAIL single_latency got=%0d exp=%0d", lat, MULT_LAT_RTL + 1);
    end
    checks++;
    if (prod !== 128'h1_FFFF_FFFF_FFFF_FFFE) begin
      failures++; $display("FAIL single_product got=%h exp=%h", prod, 128'h1_FFFF_FFFF_FFFF_FFFE);
    end
    sb.delete();
  endtask

  task automatic test_signed();
    logic iss, pop, done;
    logic [127:0] got;
    logic [CW-1:0] infl;
    done = 1'b0;
    cycle(1'b1, 64'hFFFF_FFFF_FFFF_FFFD, 64'd5, 1'b1, 1'b1, iss, pop, got, infl);
    for (int k = 0; k < 20 && !done; k++) begin
      cycle(1'b0, '0, '0, 1'b0, 1'b1, iss, pop, got, infl);
      if (k == 0) begin
        checks++;
        if (bus5.o_mult_ns !== 1'b1 || bus5.o_mult_a !== 64'hFFFF_FFFF_FFFF_FFFD) begin
          failures++;
          $display("FAIL signed_issue ns=%b a=%h exp ns=1 a=fffffffffffffffd",
                   bus5.o_mult_ns, bus5.o_mult_a);
        end
      end
      if (pop) begin
        done = 1'b1;
        checks++;
        if (got !== 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFF1) begin
          failures++; $display("FAIL signed_product got=%h exp=-15", got);
        end
        if (sb.size() > 0) sb.delete();
      end
    end
    checks++;
    if (!done) begin
      failures++; $display("FAIL signed_timeout got=no_result exp=result");
    end
  endtask

  task automatic test_back_to_back();
    logic iss, pop, v;
    logic [127:0] got, exp;
    logic [CW-1:0] infl;
    int issued_n, popped_n, drops;
    issued_n = 0; popped_n = 0; drops = 0;
    for (int cyc = 0; cyc < 400 && popped_n < 100; cyc++) begin
      v = (issued_n < 100);
      cycle(v, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 1)),
            1'b1, iss, pop, got, infl);
      if (!sel_in_ready) drops++;
      if (iss) issued_n++;
      if (pop) begin
        popped_n++;
        checks++;
        if (sb.size() == 0) begin
          failures++; $display("FAIL b2b_extra got=%h exp=none", got);
        end else begin
          exp = sb.pop_front();
          if (got !== exp) begin
            failures++; $display("FAIL b2b_result got=%h exp=%h", got, exp);
          end
        end
      end
    end
    checks++;
    if (drops != 0) begin
      failures++; $display("FAIL b2b_ready_drop got=%0d exp=0", drops);
    end
    checks++;
    if (popped_n != 100 || sb.size() != 0) begin
      failures++; $display("FAIL b2b_count got=%0d left=%0d exp=100 left=0", popped_n, sb.size());
    end
  endtask

  task automatic test_backpressure();
    logic iss, pop;
    logic [127:0] got, exp;
    logic [CW-1:0] infl;
    int acc, drained;
    acc = 0; drained = 0;
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 1)),
            1'b0, iss, pop, got, infl);
      if (iss) acc++;
    end
    checks++;
    if (acc != FIFO_DEP_DEF) begin
      failures++; $display("FAIL bp_accepted got=%0d exp=%0d", acc, FIFO_DEP_DEF);
    end
    checks++;
    if (sel_in_ready !== 1'b0 || int'(sel_inflight) != FIFO_DEP_DEF) begin
      failures++;
      $display("FAIL bp_full ready=%b inflight=%0d exp ready=0 inflight=%0d",
               sel_in_ready, sel_inflight, FIFO_DEP_DEF);
    end
    for (int i = 0; i < 40 && drained < FIFO_DEP_DEF; i++) begin
      cycle(1'b0, '0, '0, 1'b0, 1'b1, iss, pop, got, infl);
      if (pop) begin
        drained++;
        checks++;
        if (sb.size() == 0) begin
          failures++; $display("FAIL bp_extra got=%h exp=none", got);
        end else begin
          exp = sb.pop_front();
          if (got !== exp) begin
            failures++; $display("FAIL bp_result got=%h exp=%h", got, exp);
          end
        end
      end
    end
    checks++;
    if (drained != FIFO_DEP_DEF) begin
      failures++; $display("FAIL bp_drained got=%0d exp=%0d", drained, FIFO_DEP_DEF);
    end
    cycle(1'b1, 64'd7, 64'd9, 1'b0, 1'b1, iss, pop, got, infl);
    checks++;
    if (iss !== 1'b1) begin
      failures++; $display("FAIL bp_resume got=%b exp=1", iss);
    end
    for (int i = 0; i < 20 && sb.size() > 0; i++) begin
      cycle(1'b0, '0, '0, 1'b0, 1'b1, iss, pop, got, infl);
      if (pop) begin
        checks++;
        exp = sb.pop_front();
        if (got !== exp) begin
          failures++; $display("FAIL bp_resume_result got=%h exp=%h", got, exp);
        end
      end
    end
    checks++;
    if (sb.size() != 0) begin
      failures++; $display("FAIL bp_leftover got=%0d exp=0", sb.size());
    end
  endtask

  task automatic test_reset_flush();
    logic iss, pop;
    logic [127:0] got;
    logic [CW-1:0] infl;
    int acc, stale;
    acc = 0; stale = 0;
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, {$urandom, $urandom}, {$urandom, $urandom}, 1'b0, 1'b0, iss, pop, got, infl);
      if (iss) acc++;
    end
    repeat (3) cycle(1'b0, '0, '0, 1'b0, 1'b0, iss, pop, got, infl);
    // Two results now sit in the FIFO and three are still in the multiplier.
    @(negedge clk);
    #1;
    checks++;
    if (acc != 5 || sel_out_valid !== 1'b1 || int'(sel_inflight) != 5) begin
      failures++;
      $display("FAIL flush_pre acc=%0d valid=%b inflight=%0d exp 5 1 5",
               acc, sel_out_valid, sel_inflight);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (sel_out_valid !== 1'b0 || sel_inflight !== '0) begin
      failures++;
      $display("FAIL flush_post valid=%b inflight=%0d exp 0 0", sel_out_valid, sel_inflight);
    end
    sb.delete();
    for (int i = 0; i < 20; i++) begin
      cycle(1'b0, '0, '0, 1'b0, 1'b1, iss, pop, got, infl);
      if (pop || infl !== '0) stale++;
    end
    checks++;
    if (stale != 0) begin
      failures++; $display("FAIL flush_stale got=%0d exp=0", stale);
    end
  endtask

  task automatic test_random_gate();
    logic iss, pop;
    logic [127:0] got, exp;
    logic [CW-1:0] infl;
    int exp_infl, bad_infl;
    bad_infl = 0;
    use8 = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    for (int cyc = 0; cyc < 400; cyc++) begin
      exp_infl = sb.size();
      cycle(1'($urandom_range(0, 1)), {$urandom, $urandom}, {$urandom, $urandom},
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), iss, pop, got, infl);
      if (int'(infl) != exp_infl) begin
        bad_infl++;
        if (bad_infl < 5) $display("FAIL gate_inflight got=%0d exp=%0d", infl, exp_infl);
      end
      if (pop) begin
        checks++;
        if (sb.size() == 0) begin
          failures++; $display("FAIL gate_extra got=%h exp=none", got);
        end else begin
          exp = sb.pop_front();
          if (got !== exp) begin
            failures++; $display("FAIL gate_result got=%h exp=%h", got, exp);
          end
        end
      end
    end
    checks++;
    if (bad_infl != 0) begin
      failures++; $display("FAIL gate_inflight_total got=%0d exp=0", bad_infl);
    end
    for (int i = 0; i < 60 && sb.size() > 0; i++) begin
      cycle(1'b0, '0, '0, 1'b0, 1'b1, iss, pop, got, infl);
      if (pop) begin
        checks++;
        exp = sb.pop_front();
        if (got !== exp) begin
          failures++; $display("FAIL gate_drain got=%h exp=%h", got, exp);
        end
      end
    end
    @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0 || sel_inflight !== '0 || sel_out_valid !== 1'b0) begin
      failures++;
      $display("FAIL gate_end left=%0d inflight=%0d valid=%b exp 0 0 0",
               sb.size(), sel_inflight, sel_out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_single_unsigned();
    test_signed();
    test_back_to_back();
    test_backpressure();
    test_reset_flush();
    test_random_gate();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
